// File: rtl/regfile_read_unit_if.sv
// Bus bundle for regfile_read_unit: writeback write port, decode read-request
// handshake and buffered operand response handshake.
interface regfile_read_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  WriteEn;
  logic [ADDR_WIDTH-1:0] WriteAddr;
  logic [DATA_WIDTH-1:0] WriteData;

  logic                  ReqValid;
  logic                  ReqReady;
  logic [ADDR_WIDTH-1:0] ReqAddrA;
  logic [ADDR_WIDTH-1:0] ReqAddrB;

  logic                  RespValid;
  logic                  RespReady;
  logic [DATA_WIDTH-1:0] RespDataA;
  logic [DATA_WIDTH-1:0] RespDataB;

  modport master (
    output WriteEn, WriteAddr, WriteData,
    output ReqValid, ReqAddrA, ReqAddrB,
    output RespReady,
    input  ReqReady, RespValid, RespDataA, RespDataB
  );

  modport slave (
    input  WriteEn, WriteAddr, WriteData,
    input  ReqValid, ReqAddrA, ReqAddrB,
    input  RespReady,
    output ReqReady, RespValid, RespDataA, RespDataB
  );
endinterface

// File: rtl/regfile_read_unit.sv
// Register array with one write port, dual-operand reads with same-cycle write
// bypass, and a two-entry response FIFO so a stalled consumer keeps its operands.
module regfile_read_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input logic                 Clk,
  input logic                 Reset,
  regfile_read_unit_if.slave  bus
);
  localparam int         NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [1:0] DEPTH_L  = 2'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e                  r_state;
  occ_e                  w_state_next;
  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_regs   [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_slot_a [2];
  logic [DATA_WIDTH-1:0] r_slot_b [2];

  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_count;
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;

  function automatic logic [DATA_WIDTH-1:0] f_operand(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] entry
  );
    logic [DATA_WIDTH-1:0] v;
    if (addr == '0)
      v = '0;
    else if (we && (waddr == addr))
      v = wdata;
    else
      v = entry;
    return v;
  endfunction

  // r_run holds ReqReady low until the first edge after reset release
  always_comb begin
    w_count       = r_state;
    bus.ReqReady  = r_run && (w_count < DEPTH_L);
    bus.RespValid = (r_state != EMPTY);
    bus.RespDataA = bus.RespValid ? r_slot_a[0] : '0;
    bus.RespDataB = bus.RespValid ? r_slot_b[0] : '0;
    w_push        = bus.ReqValid && bus.ReqReady;
    w_pop         = bus.RespValid && bus.RespReady;
    w_rd_a        = f_operand(bus.ReqAddrA, bus.WriteEn, bus.WriteAddr,
                              bus.WriteData, r_regs[bus.ReqAddrA]);
    w_rd_b        = f_operand(bus.ReqAddrB, bus.WriteEn, bus.WriteAddr,
                              bus.WriteData, r_regs[bus.ReqAddrB]);
  end

  always_comb begin
    w_state_next = r_state;
    unique case ({w_push, w_pop})
      2'b10: begin
        if (r_state == EMPTY)    w_state_next = ONE;
        else if (r_state == ONE) w_state_next = FULL;
      end
      2'b01: begin
        if (r_state == FULL)     w_state_next = ONE;
        else if (r_state == ONE) w_state_next = EMPTY;
      end
      default: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= EMPTY;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_run   <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (bus.WriteEn && (bus.WriteAddr != '0)) begin
      r_regs[bus.WriteAddr] <= bus.WriteData;
    end
  end

  // Slot 0 is always the head; push+pop is only possible with one entry
  // queued, in which case the new entry replaces the departing head.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_slot_a[i] <= '0;
        r_slot_b[i] <= '0;
      end
    end else begin
      if (w_push && ((r_state == EMPTY) || ((r_state == ONE) && w_pop))) begin
        r_slot_a[0] <= w_rd_a;
        r_slot_b[0] <= w_rd_b;
      end else if (w_pop) begin
        r_slot_a[0] <= r_slot_a[1];
        r_slot_b[0] <= r_slot_b[1];
      end
      if (w_push && (r_state == ONE) && !w_pop) begin
        r_slot_a[1] <= w_rd_a;
        r_slot_b[1] <= w_rd_b;
      end
    end
  end
endmodule

// File: tb/tb_regfile_read_unit.sv
// Randomized and directed bench for regfile_read_unit against a queue-based
// reference model of the register file and response buffer.
module tb_regfile_read_unit;
  localparam int DW = 32;
  localparam int AW = 5;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  regfile_read_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_read_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [DW-1:0]   m_regs [32];
  logic [2*DW-1:0] m_q [$];
  bit              m_run;
  int              n_cmp = 0;
  int              n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.WriteEn && bus.WriteAddr == a) return bus.WriteData;
    return m_regs[a];
  endfunction

  task automatic check_outputs();
    chk("ReqReady", 64'(bus.ReqReady), 64'(m_run && m_q.size() < 2));
    chk("RespValid", 64'(bus.RespValid), 64'(m_q.size() != 0));
    chk("RespData", {bus.RespDataA, bus.RespDataB},
        (m_q.size() != 0) ? m_q[0] : 64'd0);
  endtask

  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit rv, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                       input bit rr);
    bus.WriteEn = we; bus.WriteAddr = wa; bus.WriteData = wd;
    bus.ReqValid = rv; bus.ReqAddrA = aa; bus.ReqAddrB = ab;
    bus.RespReady = rr;
  endtask

  task automatic drive_random();
    drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
          5'($urandom), 1'($urandom));
  endtask

  // One clock: decide accept/pop from the model, let the edge pass, update, check.
  task automatic step();
    bit acc, pop;
    logic [2*DW-1:0] pair;
    acc  = bus.ReqValid && m_run && (m_q.size() < 2);
    pop  = bus.RespReady && (m_q.size() != 0);
    pair = {m_read(bus.ReqAddrA), m_read(bus.ReqAddrB)};
    @(posedge Clk);
    #1;
    if (Reset) begin
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(pair);
      if (bus.WriteEn && bus.WriteAddr != 0) m_regs[bus.WriteAddr] = bus.WriteData;
    end
    m_run = Reset;
    check_outputs();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_q.delete();
    m_run = 0;
  endtask

  // Called just after an edge: assert reset mid-cycle, hold, release mid-cycle.
  task automatic pulse_reset(input int cycles);
    #2 Reset = 1'b0;
    #1 model_clear();
    check_outputs();
    for (int i = 0; i < cycles; i++) begin
      drive_random();
      step();
    end
    #3 Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    model_clear();
    drive_random();
    #1 check_outputs();
    for (int i = 0; i < 4; i++) begin
      drive_random();
      step();
    end
    #3 Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rst_release_ready", 64'(bus.ReqReady), 64'd1);
    drive(0, 0, 0, 1, 5, 31, 0);
    step();
    chk("rst_read", {bus.RespDataA, bus.RespDataB}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 1);
    step();

    // Basic read
    drive(1, 3, 32'h12345678, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 3, 0, 0); step();
    chk("basic", {bus.RespDataA, bus.RespDataB}, {32'h12345678, 32'h0});
    drive(0, 0, 0, 0, 0, 0, 1); step();

    // Bypass and r0
    drive(1, 7, 32'hDEADBEEF, 1, 7, 7, 0); step();
    chk("bypass", {bus.RespDataA, bus.RespDataB}, {32'hDEADBEEF, 32'hDEADBEEF});
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1); step();
    drive(0, 0, 0, 1, 0, 0, 0); step();
    chk("r0", {bus.RespDataA, bus.RespDataB}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 1); step();

    // Backpressure
    for (int i = 1; i <= 10; i++) begin
      drive(1, 5'(i), 32'(i), 0, 0, 0, 0); step();
    end
    drive(0, 0, 0, 1, 1, 1, 0); step();
    drive(0, 0, 0, 1, 2, 2, 0); step();
    chk("bp_full_ready", 64'(bus.ReqReady), 64'd0);
    drive(0, 0, 0, 1, 3, 3, 0); step();
    chk("bp_head", 64'(bus.RespDataA), 64'd1);
    drive(0, 0, 0, 1, 3, 3, 1);
    for (int i = 0; i < 6; i++) begin
      bit will_acc;
      will_acc = m_run && m_q.size() < 2;
      step();
      if (will_acc) bus.ReqValid = 1'b0;
    end

    // Simultaneous push/pop at one entry
    drive(0, 0, 0, 1, 1, 1, 0); step();
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 0, 1, 5'(i), 5'(11 - i), 1); step();
      chk("pp_ready", 64'(bus.ReqReady), 64'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 1); step();

    // Snapshot
    drive(1, 4, 32'hA, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 4, 4, 0); step();
    drive(1, 4, 32'hB, 0, 0, 0, 0); step();
    chk("snapshot", 64'(bus.RespDataA), 64'hA);
    drive(0, 0, 0, 0, 0, 0, 1); step();

    // Reset mid-operation
    drive(0, 0, 0, 1, 4, 7, 0); step();
    drive(0, 0, 0, 1, 3, 1, 0); step();
    pulse_reset(2);
    chk("post_rst_valid", 64'(bus.RespValid), 64'd0);
    drive(0, 0, 0, 1, 4, 7, 0); step();
    chk("post_rst_read", {bus.RespDataA, bus.RespDataB}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 1); step();

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      if ($urandom_range(0, 3) == 0) bus.WriteAddr = 5'($urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) bus.ReqAddrA = 5'($urandom_range(0, 3));
      step();
      if ($urandom_range(0, 299) == 0) pulse_reset(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
